oflow_mem_write_scheduler: RTL and testbench
============================================

// Module: oflow_mem_write_scheduler
// PURPOSE
// - Sequences write-back of per-object features from the PE array into the MEM buffer at end of frame.
// - Drives pe_sel / row_sel / remainder into the MEM-PE interface (4 objects per beat -> 2 buffer words).
// - Raises the buffer write strobes and the write address, and honours buffer backpressure.
// - Signals done_write to the core FSM when all objects of the frame are written.
// PARAMETERS
// - PE_NUM        24  number of PEs; must be a multiple of 4. PE_GROUPS = PE_NUM/4.
// - ROWS_PER_PE   4   object rows held per PE. MAX_OBJ = PE_NUM*ROWS_PER_PE.
// - OBJ_W         7   width of num_of_objects; must satisfy 2**OBJ_W > MAX_OBJ.
// - ADDR_W        5   width of wr_addr (beat index); must satisfy 2**ADDR_W >= ceil(MAX_OBJ/4).
// PORTS
// - clk             in   1                     core clock, rising edge
// - reset_N         in   1                     asynchronous reset, active-low
// - start_write     in   1                     1-cycle pulse: begin write-back of the current frame
// - num_of_objects  in   OBJ_W                 objects in frame; sampled on an accepted start_write
// - buffer_ready    in   1                     MEM buffer accepts a word pair this cycle
// - pe_sel          out  clog2(PE_GROUPS)      selects PE group (PEs 4*pe_sel .. 4*pe_sel+3)
// - row_sel         out  clog2(ROWS_PER_PE)    row read out of each selected PE
// - remainder       out  2                     valid objects in beat mod 4 (0 = four valid)
// - we_0            out  1                     write strobe, buffer word 0 (objects 0,1 of beat)
// - we_1            out  1                     write strobe, buffer word 1 (objects 2,3 of beat)
// - wr_addr         out  ADDR_W                beat index b; buffer stores pair at words 2b, 2b+1
// - busy            out  1                     high from accepted start until done_write
// - done_write      out  1                     1-cycle pulse after the last beat is accepted
// BEHAVIOUR
// - Mapping:
//   - object k lives in PE (k mod PE_NUM), row (k div PE_NUM).
//   - beat b covers objects 4b..4b+3, with pe_sel = b mod PE_GROUPS and row_sel = b div PE_GROUPS.
// - State machine: IDLE -> WRITE -> DONE -> IDLE.
//   - IDLE: on start_write, latch N = min(num_of_objects, MAX_OBJ) and clear the beat counter.
//     - If N == 0, go to DONE (no writes); otherwise go to WRITE.
//   - WRITE: cnt = min(4, N - 4b).
//     - remainder = cnt[1:0].
//     - we_0 = buffer_ready.
//     - we_1 = buffer_ready && cnt >= 3.
//     - Beat is accepted when buffer_ready == 1; then b increments.
//     - When the accepted beat is the last one (4b+4 >= N), go to DONE.
//   - DONE: done_write = 1 for exactly one cycle; go to IDLE.
// - Counters:
//   - b, pe_sel, row_sel, wr_addr are registers.
//   - pe_sel wraps PE_GROUPS-1 -> 0, and row_sel increments on that same wrap.
//   - remainder, we_0, we_1 are combinational from state and counters.
// - Latency:
//   - start_write in cycle t -> first beat presented in cycle t+1.
//   - Last beat accepted in cycle u -> done_write in cycle u+1 and busy low from cycle u+2.
// - Backpressure: while buffer_ready = 0 in WRITE, hold pe_sel/row_sel/wr_addr/remainder stable; strobes are 0.
// - start_write while busy: ignored, with no effect on the latched N or the counters.
// - busy = (state != IDLE).
// - Outside WRITE: we_0 = we_1 = 0, and remainder = 0.
// - Reset (async, any time, including mid-frame):
//   - state IDLE, and all counters and N are 0.
//   - all outputs 0 (pe_sel, row_sel, remainder, we_0, we_1, wr_addr, busy, done_write).
//   - Writes in progress are abandoned; no further strobes until a new start_write.
// TESTING (PE_NUM=8, ROWS_PER_PE=4)
// - N=10, ready=1: 3 beats (pe,row,rem,we0,we1,addr) = (0,0,0,1,1,0), (1,0,0,1,1,1), (0,1,2,1,0,2); done_write one cycle after beat 3.
// - N=0: no strobes, busy high 1 cycle, done_write in cycle t+1; N=1: single beat rem=1, we0=1, we1=0.
// - N=7, buffer_ready low 3 cycles during beat 0: outputs held, no strobes; then beats (0,0,0,1,1,0), (1,0,3,1,1,1).
// - N=50 (>MAX 32): clamped, 8 beats, last beat pe=1, row=3, addr=7, rem=0.
// - start_write pulsed mid-frame with N=3: ignored, original sequence completes unchanged.
// - reset_N low during beat 1: all outputs 0 asynchronously; after release, idle until new start_write.

Source files
------------

// File: rtl/oflow_mem_write_scheduler_if.sv
// Purpose : bundles the control and write-back signals between the core FSM,
//           the MEM-PE interface and the MEM buffer for the object-feature
//           write scheduler.
// Signals : start_write / num_of_objects  - frame write-back request from core
//           buffer_ready                   - MEM buffer can take a word pair
//           pe_sel / row_sel / remainder   - MEM-PE readout selection
//           we_0 / we_1 / wr_addr          - buffer write strobes and beat address
//           busy / done_write              - status back to the core FSM
// Modports: slave  - the scheduler (consumes the request, drives everything else)
//           master - the core/buffer side
interface oflow_mem_write_scheduler_if #(
    parameter int unsigned PE_NUM      = 24,
    parameter int unsigned ROWS_PER_PE = 4,
    parameter int unsigned OBJ_W       = 7,
    parameter int unsigned ADDR_W      = 5
);
    localparam int unsigned PE_GROUPS = PE_NUM / 4;
    localparam int unsigned PE_SEL_W  = (PE_GROUPS > 1) ? $clog2(PE_GROUPS) : 1;
    localparam int unsigned ROW_W     = (ROWS_PER_PE > 1) ? $clog2(ROWS_PER_PE) : 1;

    logic                start_write;
    logic [OBJ_W-1:0]    num_of_objects;
    logic                buffer_ready;
    logic [PE_SEL_W-1:0] pe_sel;
    logic [ROW_W-1:0]    row_sel;
    logic [1:0]          remainder;
    logic                we_0;
    logic                we_1;
    logic [ADDR_W-1:0]   wr_addr;
    logic                busy;
    logic                done_write;

    modport slave (
        input  start_write, num_of_objects, buffer_ready,
        output pe_sel, row_sel, remainder, we_0, we_1, wr_addr, busy, done_write
    );

    modport master (
        output start_write, num_of_objects, buffer_ready,
        input  pe_sel, row_sel, remainder, we_0, we_1, wr_addr, busy, done_write
    );
endinterface

// File: rtl/oflow_mem_write_scheduler.sv
// Purpose : at end of frame, walks the per-object features held in the PE
//           array and writes them into the MEM buffer, four objects (two
//           buffer words) per beat, honouring buffer backpressure.
// Ports   : clk      - core clock, rising edge
//           reset_N  - asynchronous reset, active-low
//           bus      - scheduler side of oflow_mem_write_scheduler_if:
//                      start_write/num_of_objects/buffer_ready in,
//                      pe_sel/row_sel/remainder/we_0/we_1/wr_addr/busy/done_write out
module oflow_mem_write_scheduler #(
    parameter int unsigned PE_NUM      = 24,
    parameter int unsigned ROWS_PER_PE = 4,
    parameter int unsigned OBJ_W       = 7,
    parameter int unsigned ADDR_W      = 5
) (
    input  logic                          clk,
    input  logic                          reset_N,
    oflow_mem_write_scheduler_if.slave    bus
);
    localparam int unsigned PE_GROUPS = PE_NUM / 4;
    localparam int unsigned PE_SEL_W  = (PE_GROUPS > 1) ? $clog2(PE_GROUPS) : 1;
    localparam int unsigned ROW_W     = (ROWS_PER_PE > 1) ? $clog2(ROWS_PER_PE) : 1;
    localparam int unsigned MAX_OBJ   = PE_NUM * ROWS_PER_PE;

    localparam logic [OBJ_W-1:0]    MAX_OBJ_V  = OBJ_W'(MAX_OBJ);
    localparam logic [OBJ_W-1:0]    FOUR_V     = OBJ_W'(4);
    localparam logic [PE_SEL_W-1:0] PE_LAST_V  = PE_SEL_W'(PE_GROUPS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t              state_q,    state_d;
    // Objects still to be written (N - 4b); stands in for the latched N.
    logic [OBJ_W-1:0]    left_q,     left_d;
    logic [PE_SEL_W-1:0] pe_sel_q,   pe_sel_d;
    logic [ROW_W-1:0]    row_sel_q,  row_sel_d;
    logic [ADDR_W-1:0]   wr_addr_q,  wr_addr_d;

    logic [OBJ_W-1:0]    n_clamped;
    logic [2:0]          cnt;
    logic [1:0]          remainder_c;
    logic                we_0_c;
    logic                we_1_c;

    always_ff @(posedge clk or negedge reset_N) begin
        if (!reset_N) begin
            state_q   <= IDLE;
            left_q    <= '0;
            pe_sel_q  <= '0;
            row_sel_q <= '0;
            wr_addr_q <= '0;
        end else begin
            state_q   <= state_d;
            left_q    <= left_d;
            pe_sel_q  <= pe_sel_d;
            row_sel_q <= row_sel_d;
            wr_addr_q <= wr_addr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        left_d      = left_q;
        pe_sel_d    = pe_sel_q;
        row_sel_d   = row_sel_q;
        wr_addr_d   = wr_addr_q;
        remainder_c = 2'd0;
        we_0_c      = 1'b0;
        we_1_c      = 1'b0;

        n_clamped = (bus.num_of_objects > MAX_OBJ_V) ? MAX_OBJ_V : bus.num_of_objects;
        // Valid objects in the current beat: min(4, remaining).
        cnt = (left_q >= FOUR_V) ? 3'd4 : left_q[2:0];

        case (state_q)
            IDLE: begin
                if (bus.start_write) begin
                    left_d    = n_clamped;
                    pe_sel_d  = '0;
                    row_sel_d = '0;
                    wr_addr_d = '0;
                    state_d   = (n_clamped == '0) ? DONE : WRITE;
                end
            end

            WRITE: begin
                remainder_c = cnt[1:0];
                we_0_c      = bus.buffer_ready;
                we_1_c      = bus.buffer_ready && (cnt >= 3'd3);
                if (bus.buffer_ready) begin
                    wr_addr_d = wr_addr_q + 1'b1;
                    if (pe_sel_q == PE_LAST_V) begin
                        pe_sel_d  = '0;
                        row_sel_d = row_sel_q + 1'b1;
                    end else begin
                        pe_sel_d  = pe_sel_q + 1'b1;
                    end
                    if (left_q <= FOUR_V) begin
                        left_d  = '0;
                        state_d = DONE;
                    end else begin
                        left_d  = left_q - FOUR_V;
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.pe_sel     = pe_sel_q;
    assign bus.row_sel    = row_sel_q;
    assign bus.wr_addr    = wr_addr_q;
    assign bus.remainder  = remainder_c;
    assign bus.we_0       = we_0_c;
    assign bus.we_1       = we_1_c;
    assign bus.busy       = (state_q != IDLE);
    assign bus.done_write = (state_q == DONE);

endmodule

// File: tb/tb_oflow_mem_write_scheduler.sv
module tb_oflow_mem_write_scheduler;
    localparam int unsigned PE_NUM      = 8;
    localparam int unsigned ROWS_PER_PE = 4;
    localparam int unsigned OBJ_W       = 7;
    localparam int unsigned ADDR_W      = 5;
    localparam int unsigned PE_GROUPS   = PE_NUM / 4;
    localparam int unsigned MAX_OBJ     = PE_NUM * ROWS_PER_PE;

    typedef struct packed {
        logic [0:0]        pe;
        logic [1:0]        row;
        logic [1:0]        rem;
        logic              we1;
        logic [ADDR_W-1:0] addr;
    } beat_t;

    logic clk;
    logic reset_N;

    int unsigned n_checks;
    int unsigned n_errors;
    beat_t       exp_q[$];

    oflow_mem_write_scheduler_if #(
        .PE_NUM(PE_NUM), .ROWS_PER_PE(ROWS_PER_PE), .OBJ_W(OBJ_W), .ADDR_W(ADDR_W)
    ) bus_if ();

    oflow_mem_write_scheduler #(
        .PE_NUM(PE_NUM), .ROWS_PER_PE(ROWS_PER_PE), .OBJ_W(OBJ_W), .ADDR_W(ADDR_W)
    ) dut (
        .clk     (clk),
        .reset_N (reset_N),
        .bus     (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model: expected beat sequence for a frame of n objects.
    task automatic push_expected(input int unsigned n, output int unsigned nb);
        int unsigned nc;
        int unsigned cnt;
        beat_t       e;
        nc = (n > MAX_OBJ) ? MAX_OBJ : n;
        nb = (nc + 3) / 4;
        for (int unsigned b = 0; b < nb; b++) begin
            cnt    = nc - 4 * b;
            if (cnt > 4) cnt = 4;
            e.pe   = 1'(b % PE_GROUPS);
            e.row  = 2'(b / PE_GROUPS);
            e.rem  = 2'(cnt % 4);
            e.we1  = (cnt >= 3);
            e.addr = ADDR_W'(b);
            exp_q.push_back(e);
        end
    endtask

    // Output monitor: every accepted beat must match the head of the scoreboard.
    always @(negedge clk) begin
        if (reset_N) begin
            if (!bus_if.buffer_ready)
                check_eq("we_during_stall", {bus_if.we_0, bus_if.we_1}, 0);
            if (bus_if.we_1 && !bus_if.we_0)
                check_eq("we1_without_we0", 1, 0);
            if (bus_if.we_0) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_strobe", 1, 0);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    check_eq("pe_sel",    bus_if.pe_sel,    e.pe);
                    check_eq("row_sel",   bus_if.row_sel,   e.row);
                    check_eq("remainder", bus_if.remainder, e.rem);
                    check_eq("we_1",      bus_if.we_1,      e.we1);
                    check_eq("wr_addr",   bus_if.wr_addr,   e.addr);
                end
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_pe_sel"},     bus_if.pe_sel,     0);
        check_eq({tag, "_row_sel"},    bus_if.row_sel,    0);
        check_eq({tag, "_remainder"},  bus_if.remainder,  0);
        check_eq({tag, "_we_0"},       bus_if.we_0,       0);
        check_eq({tag, "_we_1"},       bus_if.we_1,       0);
        check_eq({tag, "_wr_addr"},    bus_if.wr_addr,    0);
        check_eq({tag, "_busy"},       bus_if.busy,       0);
        check_eq({tag, "_done_write"}, bus_if.done_write, 0);
    endtask

    task automatic run_frame(input int unsigned n, input int unsigned stall_cycles, input bit mid_start);
        int unsigned nb;
        int unsigned cycles;
        int unsigned beat_idx;
        int unsigned stalled;
        bit          done_seen;
        push_expected(n, nb);
        @(posedge clk); #1;
        bus_if.start_write    = 1'b1;
        bus_if.num_of_objects = OBJ_W'(n);
        bus_if.buffer_ready   = 1'b1;
        cycles    = 0;
        beat_idx  = 0;
        stalled   = 0;
        done_seen = 1'b0;
        while (!done_seen && cycles < 100) begin
            @(posedge clk); #1;
            cycles++;
            bus_if.start_write = (mid_start && cycles == 2);
            if (mid_start && cycles == 2) bus_if.num_of_objects = OBJ_W'(3);
            if (beat_idx == 0 && nb > 0 && stalled < stall_cycles) begin
                bus_if.buffer_ready = 1'b0;
                stalled++;
            end else begin
                bus_if.buffer_ready = 1'b1;
                if (beat_idx < nb) beat_idx++;
            end
            @(negedge clk);
            if (!bus_if.buffer_ready && exp_q.size() > 0) begin
                check_eq("hold_pe_sel",    bus_if.pe_sel,    exp_q[0].pe);
                check_eq("hold_row_sel",   bus_if.row_sel,   exp_q[0].row);
                check_eq("hold_wr_addr",   bus_if.wr_addr,   exp_q[0].addr);
                check_eq("hold_remainder", bus_if.remainder, exp_q[0].rem);
            end
            check_eq("busy_in_frame", bus_if.busy, 1);
            if (bus_if.done_write) begin
                done_seen = 1'b1;
                check_eq("done_latency", cycles, nb + stalled + 1);
            end
        end
        if (!done_seen) check_eq("done_timeout", 0, 1);
        check_eq("beats_outstanding", exp_q.size(), 0);
        exp_q.delete();
        @(posedge clk); #1;
        bus_if.buffer_ready = 1'b1;
        @(negedge clk);
        check_eq("busy_after_done", bus_if.busy, 0);
        check_eq("done_one_cycle",  bus_if.done_write, 0);
    endtask

    initial begin
        int unsigned nb;
        n_checks = 0;
        n_errors = 0;
        reset_N               = 1'b0;
        bus_if.start_write    = 1'b0;
        bus_if.num_of_objects = '0;
        bus_if.buffer_ready   = 1'b1;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1;
        reset_N = 1'b1;

        run_frame(10, 0, 1'b0);
        run_frame(0,  0, 1'b0);
        run_frame(1,  0, 1'b0);
        run_frame(7,  3, 1'b0);
        run_frame(50, 0, 1'b0);
        run_frame(20, 0, 1'b1);

        // Asynchronous reset during beat 1 of a frame.
        push_expected(20, nb);
        @(posedge clk); #1;
        bus_if.start_write    = 1'b1;
        bus_if.num_of_objects = OBJ_W'(20);
        bus_if.buffer_ready   = 1'b1;
        @(posedge clk); #1;
        bus_if.start_write = 1'b0;
        @(posedge clk); #1;
        @(negedge clk); #2;
        reset_N = 1'b0;
        #1;
        check_all_zero("midreset");
        check_eq("midreset_beats_seen", nb - exp_q.size(), 2);
        exp_q.delete();
        @(posedge clk); #1;
        reset_N = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check_eq("idle_after_reset_busy", bus_if.busy, 0);
            check_eq("idle_after_reset_we_0", bus_if.we_0, 0);
        end

        run_frame(5, 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
